// File: rtl/mux_alu_skid_pkg.sv
// rtl/mux_alu_skid_pkg.sv - shared ALU select encodings, status flag positions and defaults
package mux_alu_skid_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NUM_IN = 5;

    typedef enum logic [2:0] {
        SEL_ADD  = 3'd0,
        SEL_AND  = 3'd1,
        SEL_OR   = 3'd2,
        SEL_NOT  = 3'd3,
        SEL_ZERO = 3'd4
    } alu_sel_e;

    // Bit positions of the flags in the processor status register
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_ERR  = 2;

    // Legacy behaviour: the SEL_ZERO slot always reads as zero
    localparam logic [DEF_NUM_IN-1:0] DEF_ZERO_MASK = 5'b10000;

endpackage

// File: rtl/mux_alu_n.sv
// rtl/mux_alu_n.sv - combinational N:1 result select with zero mask, illegal-select detect and flags
module mux_alu_n
    import mux_alu_skid_pkg::*;
#(
    parameter int                WIDTH     = DEF_WIDTH,
    parameter int                NUM_IN    = DEF_NUM_IN,
    parameter int                SEL_W     = 3,
    parameter logic [NUM_IN-1:0] ZERO_MASK = DEF_ZERO_MASK
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data,
    output logic                    zero,
    output logic                    neg,
    output logic                    err
);

    // err starts set and is cleared only when sel matches a real input slot
    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                err = 1'b0;
                if (!ZERO_MASK[k]) begin
                    data = in_data[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign zero = (data == '0);
    assign neg  = data[WIDTH-1];

endmodule

// File: rtl/mux_alu_skid.sv
// rtl/mux_alu_skid.sv - registered ALU result select behind a two-entry skid buffer
module mux_alu_skid
    import mux_alu_skid_pkg::*;
#(
    parameter int                WIDTH     = DEF_WIDTH,
    parameter int                NUM_IN    = DEF_NUM_IN,
    parameter int                SEL_W     = 3,
    parameter logic [NUM_IN-1:0] ZERO_MASK = DEF_ZERO_MASK
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_zero,
    output logic                    out_neg,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_zero;
    logic             sel_neg;
    logic             sel_err;

    mux_alu_n #(
        .WIDTH     (WIDTH),
        .NUM_IN    (NUM_IN),
        .SEL_W     (SEL_W),
        .ZERO_MASK (ZERO_MASK)
    ) u_mux (
        .in_data (in_data),
        .sel     (sel),
        .data    (sel_data),
        .zero    (sel_zero),
        .neg     (sel_neg),
        .err     (sel_err)
    );

    logic [WIDTH-1:0] o_data, s_data;
    logic             o_zero, s_zero;
    logic             o_neg,  s_neg;
    logic             o_err,  s_err;
    logic             o_valid, s_valid;

    logic accept, consume, load_o, load_s, s_valid_next;

    assign accept  = in_valid && in_ready;
    assign consume = o_valid && out_ready;

    // accept implies S is empty, since in_ready mirrors !s_valid
    assign load_o       = accept && (!o_valid || (consume && !s_valid));
    assign load_s       = accept && !load_o;
    assign s_valid_next = load_s || (s_valid && !consume);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_data   <= '0;
            o_zero   <= 1'b0;
            o_neg    <= 1'b0;
            o_err    <= 1'b0;
            o_valid  <= 1'b0;
            s_data   <= '0;
            s_zero   <= 1'b0;
            s_neg    <= 1'b0;
            s_err    <= 1'b0;
            s_valid  <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            if (load_o) begin
                o_data  <= sel_data;
                o_zero  <= sel_zero;
                o_neg   <= sel_neg;
                o_err   <= sel_err;
                o_valid <= 1'b1;
            end else if (consume) begin
                if (s_valid) begin
                    o_data  <= s_data;
                    o_zero  <= s_zero;
                    o_neg   <= s_neg;
                    o_err   <= s_err;
                    o_valid <= 1'b1;
                end else begin
                    o_data  <= '0;
                    o_zero  <= 1'b0;
                    o_neg   <= 1'b0;
                    o_err   <= 1'b0;
                    o_valid <= 1'b0;
                end
            end

            if (load_s) begin
                s_data  <= sel_data;
                s_zero  <= sel_zero;
                s_neg   <= sel_neg;
                s_err   <= sel_err;
                s_valid <= 1'b1;
            end else if (consume && s_valid) begin
                s_valid <= 1'b0;
            end

            in_ready <= !s_valid_next;
        end
    end

    assign out_data  = o_data;
    assign out_zero  = o_zero;
    assign out_neg   = o_neg;
    assign out_err   = o_err;
    assign out_valid = o_valid;

endmodule

// File: tb/tb_mux_alu_skid.sv
// tb/tb_mux_alu_skid.sv - directed self-checking bench for mux_alu_skid
module tb_mux_alu_skid;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [39:0] in_data;
    logic [2:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_zero;
    logic        out_neg;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;
    logic [10:0] sb_q[$];
    int acc_n;
    int cons_n;

    mux_alu_skid dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] obs();
        return {out_err, out_neg, out_zero, out_data};
    endfunction

    // {err, neg, zero, data}: inputs 0..3 pass, 4 masked, 5..7 illegal
    function automatic logic [10:0] model(input logic [2:0] s, input logic [39:0] d);
        logic [7:0] v;
        logic       e;
        e = (s >= 3'd5);
        v = (s < 3'd4) ? d[s*8 +: 8] : 8'h00;
        return {e, v[7], (v == 8'h00), v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [2:0] s, input logic [10:0] exp);
        sel       = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_beat"}, 32'(obs()), 32'(exp));
        tick();
        chk({tag, "_gone"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_phase(input int n, input int mode);
        logic        stalled;
        logic [10:0] held;
        logic        acc;
        logic        cons;
        stalled = 1'b0;
        held    = '0;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       begin in_valid = 1'b1;           out_ready = 1'b1;           end
                1:       begin in_valid = (i % 3) != 2;   out_ready = (i % 5) < 2;    end
                2:       begin in_valid = (i % 4) != 0;   out_ready = (i % 3) == 0;   end
                default: begin in_valid = 1'b0;           out_ready = 1'b1;           end
            endcase
            sel     = 3'(i * 3 + mode);
            in_data = {8'(i * 13), 8'(i * 7 + 1), 8'(i * 29 + 128), 8'(i * 5), 8'(i * 11 + 3)};

            if (stalled) chk("hold", 32'(obs()), 32'(held));
            chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(sb_q.size() < 2));

            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (cons) begin
                cons_n++;
                if (sb_q.size() == 0) chk("spurious", 32'd1, 32'd0);
                else chk("order", 32'(obs()), 32'(sb_q.pop_front()));
            end
            if (acc) begin
                acc_n++;
                sb_q.push_back(model(sel, in_data));
            end
            stalled = out_valid && !out_ready;
            held    = obs();
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = '0;
        in_data   = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_beat", 32'(obs()), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        beat("sel2", 3'd2, 11'h033);
        beat("sel4_mask", 3'd4, 11'h100);
        beat("sel7_err", 3'd7, 11'h500);
        beat("sel5_err", 3'd5, 11'h500);
        in_data[7:0] = 8'h80;
        beat("sel0_neg", 3'd0, 11'h280);
        in_data[7:0] = 8'h11;

        // Back-pressure: A=0x22 into O, B=0x33 into S, C=0x44 stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 3'd1;
        tick();
        sel = 3'd2;
        chk("bp_a_valid", 32'(out_valid), 32'd1);
        chk("bp_a", 32'(out_data), 32'h22);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        tick();
        sel = 3'd3;
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_a_hold", 32'(out_data), 32'h22);
        tick();
        chk("bp_stall_ready", 32'(in_ready), 32'd0);
        chk("bp_stall_hold", 32'(out_data), 32'h22);
        out_ready = 1'b1;
        tick();
        chk("bp_b", 32'(out_data), 32'h33);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_c_valid", 32'(out_valid), 32'd1);
        chk("bp_c", 32'(out_data), 32'h44);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        acc_n  = 0;
        cons_n = 0;
        sb_q.delete();
        run_phase(20, 0);
        chk("stream_acc", 32'(acc_n), 32'd20);
        chk("stream_cons", 32'(cons_n), 32'd19);
        run_phase(4, 3);
        run_phase(60, 1);
        run_phase(60, 2);
        run_phase(6, 3);
        chk("drained", 32'(sb_q.size()), 32'd0);
        chk("drained_valid", 32'(out_valid), 32'd0);

        // Reset with two beats buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 3'd1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_beat", 32'(obs()), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("no_stale", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
